pe_array_ctrl: RTL and testbench

//   Sequencer for the MxN systolic pe_array. On a start request it clears the PE

---
 rtl/pe_array_ctrl.sv | 133 +++++++++++++
 tb/tb_pe_array_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pe_array_ctrl.sv
// Sequencer for the MxN systolic PE array: clears accumulators, streams K skewed
// operand beats, waits out the PE pipeline, then drains results one per handshake.
module pe_array_ctrl #(
  parameter int M        = 2,
  parameter int N        = 2,
  parameter int K_WIDTH  = 8,
  parameter int PIPE_LAT = 1,
  localparam int RW      = (M > 1) ? $clog2(M) : 1,
  localparam int CLW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [K_WIDTH-1:0] k_len,
  input  logic [1:0]         precision_mode,
  output logic               busy,
  output logic               done,
  output logic [1:0]         cfg_mode,
  output logic               pe_clr,
  output logic               pe_en,
  output logic [K_WIDTH-1:0] feed_idx,
  output logic [M-1:0]       a_valid,
  output logic [N-1:0]       b_valid,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [RW-1:0]      res_row,
  output logic [CLW-1:0]     res_col
);

  // Result handshake: a result transfers on a cycle where res_valid && res_ready;
  // res_valid never drops and res_row/res_col never change until that transfer.

  localparam int CW = K_WIDTH + 1;
  localparam int WW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]         state;
  logic [K_WIDTH-1:0] k_lat;
  logic [CW-1:0]      t;
  logic [CW-1:0]      k_ext;
  logic [CW-1:0]      t_last;
  logic [WW-1:0]      wait_cnt;
  logic [RW-1:0]      row;
  logic [CLW-1:0]     col;

  // One extra counter bit keeps the skew tail of a maximum-length job from wrapping.
  assign k_ext  = {1'b0, k_lat};
  assign t_last = k_ext + CW'(M + N - 2) - CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      k_lat    <= '0;
      cfg_mode <= '0;
      t        <= '0;
      wait_cnt <= '0;
      row      <= '0;
      col      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (k_len != '0)) begin
            state    <= S_CLEAR;
            k_lat    <= k_len;
            cfg_mode <= precision_mode;
          end
        end
        S_CLEAR: begin
          state <= S_FEED;
          t     <= '0;
        end
        S_FEED: begin
          if (t == t_last) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end else begin
            t <= t + CW'(1);
          end
        end
        S_WAIT: begin
          if (wait_cnt == WW'(PIPE_LAT - 1)) begin
            state <= S_DRAIN;
            row   <= '0;
            col   <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_DRAIN: begin
          if (res_ready) begin
            if (col == CLW'(N - 1)) begin
              col <= '0;
              if (row == RW'(M - 1)) state <= S_DONE;
              else                   row   <= row + RW'(1);
            end else begin
              col <= col + CLW'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign pe_clr    = (state == S_CLEAR);
  assign pe_en     = (state == S_FEED) || (state == S_WAIT);
  assign res_valid = (state == S_DRAIN);
  assign feed_idx  = (state == S_FEED) ? t[K_WIDTH-1:0] : '0;
  assign res_row   = (state == S_DRAIN) ? row : '0;
  assign res_col   = (state == S_DRAIN) ? col : '0;

  // Row i consumes operand t-i; it is valid only once skewed in and before it runs out.
  always_comb begin
    a_valid = '0;
    b_valid = '0;
    if (state == S_FEED) begin
      for (int i = 0; i < M; i++)
        a_valid[i] = (t >= CW'(i)) && ((t - CW'(i)) < k_ext);
      for (int j = 0; j < N; j++)
        b_valid[j] = (t >= CW'(j)) && ((t - CW'(j)) < k_ext);
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Self-checking bench for pe_array_ctrl: table of jobs with expected done latency,
// per-cycle phase model, result-order scoreboard, and hand-written reset/idle sequences.
module tb_pe_array_ctrl;
  localparam int M  = 2;
  localparam int N  = 2;
  localparam int KW = 8;
  localparam int PL = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [1:0]    precision_mode = '0;
  logic          res_ready = 1'b1;
  logic          busy, done, pe_clr, pe_en, res_valid;
  logic [1:0]    cfg_mode;
  logic [KW-1:0] feed_idx;
  logic [M-1:0]  a_valid;
  logic [N-1:0]  b_valid;
  logic [0:0]    res_row;
  logic [0:0]    res_col;

  pe_array_ctrl #(.M(M), .N(N), .K_WIDTH(KW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .precision_mode(precision_mode), .busy(busy), .done(done),
    .cfg_mode(cfg_mode), .pe_clr(pe_clr), .pe_en(pe_en),
    .feed_idx(feed_idx), .a_valid(a_valid), .b_valid(b_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row), .res_col(res_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [1:0] mode;
    int         stall_at;
    int         stall_len;
    bit         extra;
    int         lat;
  } job_t;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [1:0] exp_q[$];
  job_t       jobs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int mask(input int t, input int k, input int w);
    int m = 0;
    for (int i = 0; i < w; i++)
      if (t >= i && (t - i) < k) m |= (1 << i);
    return m;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ctl"}, {pe_clr, pe_en, res_valid}, 0);
    chk({tag, "_feed"}, feed_idx, 0);
    chk({tag, "_masks"}, {a_valid, b_valid}, 0);
    chk({tag, "_rc"}, {res_row, res_col}, 0);
    chk({tag, "_cfg"}, cfg_mode, 0);
  endtask

  task automatic run_job(input job_t j);
    int  f = j.k + M + N - 2;
    int  drain_start = 2 + f + PL;
    int  acc = 0;
    int  stall_left = j.stall_len;
    int  done_seen = -1;
    int  model_done = -1;
    bit  finished = 0;
    exp_q.delete();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) exp_q.push_back({r[0], c[0]});
    start = 1'b1;
    k_len = KW'(j.k);
    precision_mode = j.mode;
    for (int d = 1; d <= j.lat + 40 && !finished; d++) begin
      @(negedge clk);
      start = 1'b0;
      res_ready = 1'b1;
      if (done === 1'b1 && done_seen < 0) done_seen = d;
      if (model_done >= 0) begin
        chk("after_done_busy", busy, 0);
        chk("after_done_done", done, 0);
        finished = 1;
      end else if (d == 1) begin
        chk("clear_pe_clr", pe_clr, 1);
        chk("clear_busy", busy, 1);
        chk("clear_pe_en", pe_en, 0);
        chk("clear_cfg", cfg_mode, j.mode);
      end else if (d < 2 + f) begin
        chk("feed_pe_en", pe_en, 1);
        chk("feed_idx", feed_idx, (d - 2) & 255);
        chk("feed_a_valid", a_valid, mask(d - 2, j.k, M));
        chk("feed_b_valid", b_valid, mask(d - 2, j.k, N));
        chk("feed_cfg", cfg_mode, j.mode);
        if (j.extra && d == 4) begin
          start = 1'b1;
          k_len = 8'd7;
          precision_mode = ~j.mode;
        end
      end else if (d < drain_start) begin
        chk("wait_pe_en", pe_en, 1);
        chk("wait_quiet", {feed_idx, a_valid, b_valid, res_valid}, 0);
      end else if (acc < M * N) begin
        chk("drain_valid", res_valid, 1);
        chk("drain_pe_en", pe_en, 0);
        chk("drain_rc", {res_row, res_col}, exp_q[0]);
        chk("drain_cfg", cfg_mode, j.mode);
        if (acc == j.stall_at && stall_left > 0) begin
          res_ready = 1'b0;
          stall_left--;
        end else begin
          void'(exp_q.pop_front());
          acc++;
        end
      end else begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_quiet", {pe_clr, pe_en, res_valid}, 0);
        model_done = d;
        if (j.extra) begin
          start = 1'b1;
          k_len = 8'd2;
        end
      end
    end
    chk("done_latency", done_seen, j.lat);
    repeat (2) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
  endtask

  initial begin
    int sa, sl;
    sa = $urandom_range(0, M * N - 1);
    sl = $urandom_range(1, 4);
    jobs[0] = '{k: 1,   mode: 2'd0, stall_at: -1, stall_len: 0,  extra: 0, lat: 10};
    jobs[1] = '{k: 3,   mode: 2'd1, stall_at: -1, stall_len: 0,  extra: 0, lat: 12};
    jobs[2] = '{k: 3,   mode: 2'd2, stall_at: 1,  stall_len: 3,  extra: 0, lat: 15};
    jobs[3] = '{k: 2,   mode: 2'd3, stall_at: -1, stall_len: 0,  extra: 1, lat: 11};
    jobs[4] = '{k: 255, mode: 2'd2, stall_at: -1, stall_len: 0,  extra: 0, lat: 264};
    jobs[5] = '{k: 5,   mode: 2'd1, stall_at: sa, stall_len: sl, extra: 0, lat: 14 + sl};

    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // start with k_len==0 must leave the controller untouched
    @(negedge clk);
    start = 1'b1;
    k_len = '0;
    precision_mode = 2'd3;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
      chk("k0_busy", busy, 0);
      chk("k0_pe_clr", pe_clr, 0);
      chk("k0_done", done, 0);
    end

    // reset in the middle of FEED (t=2)
    start = 1'b1;
    k_len = 8'd3;
    precision_mode = 2'd3;
    for (int d = 1; d <= 4; d++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_feed_idx", feed_idx, 2);
    chk("pre_rst_cfg", cfg_mode, 3);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_mid_feed");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
